// File: rtl/dpb_pkg.sv
// ---------------------------------------------------------------------------
// dpb_pkg
// Shared definitions for the dual-port block RAM stream reader.
//   dpb_state_t  : reader FSM encoding (IDLE / RUN / DRAIN / DONE)
//   SKID_DEPTH   : number of words the output skid buffer can hold; also the
//                  read credit limit (reads in flight + buffered words)
//   count_width  : width of the transfer-length field, ADDR_WIDTH + 1, so a
//                  full-depth transfer (2**ADDR_WIDTH words) is representable
// Optional feature macro used by this slice: DPB_READER_CHECKSUM_EN
// ---------------------------------------------------------------------------
package dpb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dpb_state_t;

    localparam int unsigned SKID_DEPTH = 2;

    function automatic int unsigned count_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/dpb_skid_fifo.sv
// ---------------------------------------------------------------------------
// dpb_skid_fifo
// Two-entry register FIFO holding RAM read words (plus their "last" flag)
// between the RAM read port and the valid/ready stream. Entry 0 is always the
// head, so the stream data comes straight from a register and stays stable
// while the consumer stalls.
// Ports:
//   clk, rst             clock, synchronous active-high reset (empties FIFO)
//   push, push_data,     write one word; ignored when full and not popping
//   push_last
//   pop                  remove the head word; ignored when empty
//   head_data, head_last current head entry
//   full, empty          occupancy flags
//   count                number of stored words (0..2), feeds the read credit
// ---------------------------------------------------------------------------
module dpb_skid_fifo
    import dpb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            count
);

    localparam logic [1:0] DEPTH = 2'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] slot0_data;
    logic [DATA_WIDTH-1:0] slot1_data;
    logic                  slot0_last;
    logic                  slot1_last;
    logic [1:0]            cnt;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (cnt == DEPTH);
    assign empty     = (cnt == 2'd0);
    assign count     = cnt;
    assign head_data = slot0_data;
    assign head_last = slot0_last;

    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees a slot, so a full FIFO may still accept a push.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data slots are reset too (not just the count) because
            // the head slot drives the stream data, which must read 0 in reset.
            cnt        <= 2'd0;
            slot0_data <= '0;
            slot1_data <= '0;
            slot0_last <= 1'b0;
            slot1_last <= 1'b0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0_data <= push_data;
                        slot0_last <= push_last;
                    end else begin
                        slot1_data <= push_data;
                        slot1_last <= push_last;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0_data <= slot1_data;
                    slot0_last <= slot1_last;
                    cnt        <= cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind
                    // whatever remains after the head leaves.
                    if (cnt == 2'd1) begin
                        slot0_data <= push_data;
                        slot0_last <= push_last;
                    end else begin
                        slot0_data <= slot1_data;
                        slot0_last <= slot1_last;
                        slot1_data <= push_data;
                        slot1_last <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dpb_stream_reader.sv
// ---------------------------------------------------------------------------
// dpb_stream_reader
// Reader-side controller for one port of a dual-port block RAM. After the
// writer fills the RAM and pulses i_start, this block reads i_count words
// starting at i_base_addr (wrapping modulo the RAM depth) and emits them as a
// valid/ready stream at up to one word per clock. The RAM's one-cycle read
// latency is absorbed by a two-entry skid buffer fed under a credit rule.
// Optional feature: define DPB_READER_CHECKSUM_EN to add o_checksum, the XOR
// of every beat accepted in the current transfer.
// Ports:
//   clk, rst            sole clock; synchronous active-high reset (aborts)
//   i_start             1-clk pulse, honoured only while idle
//   i_base_addr         first RAM address, sampled with i_start
//   i_count             words to read (0..2**ADDR_WIDTH), sampled with i_start
//   o_busy              high while the transfer runs, low on the o_done clk
//   o_done              1-clk pulse when the last beat is accepted (or count 0)
//   o_bram_addr         RAM address
//   o_bram_we/o_bram_din RAM write port, tied off (read-only port)
//   i_bram_dout         RAM registered read data
//   o_data, o_valid,    output stream; a beat moves on o_valid & i_ready
//   i_ready, o_last
//   o_checksum          (DPB_READER_CHECKSUM_EN only) XOR of accepted beats
// ---------------------------------------------------------------------------
module dpb_stream_reader
    import dpb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_start,
    input  logic [ADDR_WIDTH-1:0]                 i_base_addr,
    input  logic [count_width(ADDR_WIDTH)-1:0]    i_count,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic [ADDR_WIDTH-1:0]                 o_bram_addr,
    output logic                                  o_bram_we,
    output logic [DATA_WIDTH-1:0]                 o_bram_din,
    input  logic [DATA_WIDTH-1:0]                 i_bram_dout,
    output logic [DATA_WIDTH-1:0]                 o_data,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic                                  o_last
`ifdef DPB_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]                 o_checksum
`endif
);

    localparam int         CNT_W        = int'(count_width(ADDR_WIDTH));
    localparam logic [1:0] CREDIT_LIMIT = 2'(SKID_DEPTH);

    dpb_state_t            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_W-1:0]      remaining;     // reads still to be issued
    logic                  inflight;      // RAM is returning a requested word this clk
    logic                  inflight_last; // ...and that word is the final one

    logic                  skid_full;
    logic                  skid_empty;
    logic [1:0]            skid_count;
    logic                  skid_last;
    logic                  pop;
    logic                  can_issue;
    logic [1:0]            outstanding;

    assign o_bram_we   = 1'b0;
    assign o_bram_din  = '0;
    assign o_bram_addr = addr;
    assign o_valid     = ~skid_empty;
    assign o_last      = skid_last;
    assign pop         = o_valid & i_ready;

    // Credit: a read may be issued at this edge only if the words already owed
    // to the skid (in flight + buffered, minus the one leaving now) stay below
    // the skid depth. Counting the departing word keeps the pipe at 1 word/clk.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        outstanding = {1'b0, inflight} + skid_count - {1'b0, pop};
        can_issue   = 1'b0;
        if ((state == ST_RUN) && (outstanding < CREDIT_LIMIT) && (~skid_full || pop)) begin
            can_issue = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here reads the
            // pre-edge value of every other, independent of statement order.
            inflight      <= can_issue;
            inflight_last <= can_issue && (remaining == CNT_W'(1));
            o_done        <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr      <= i_base_addr;
                        remaining <= i_count;
                        if (i_count == '0) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                            o_busy <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (can_issue) begin
                        // Natural overflow of addr gives the wrap to 0.
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && skid_last) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The RAM word requested at the previous edge is on i_bram_dout now.
    dpb_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (i_bram_dout),
        .push_last (inflight_last),
        .pop       (pop),
        .head_data (o_data),
        .head_last (skid_last),
        .full      (skid_full),
        .empty     (skid_empty),
        .count     (skid_count)
    );

`ifdef DPB_READER_CHECKSUM_EN
    // Updated by the accepting edge, so the final value appears together
    // with o_done and holds until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_checksum <= '0;
        end else if ((state == ST_IDLE) && i_start) begin
            o_checksum <= '0;
        end else if (pop) begin
            o_checksum <= o_checksum ^ o_data;
        end
    end
`endif

endmodule

// File: tb/tb_dpb_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_dpb_stream_reader
// Bench for dpb_stream_reader with a behavioural RAM on the other side
// (mem[i] = i + 0x100). Each transfer is checked against the expected word
// sequence ((base + j) mod 1024) + 0x100 for j = 0..count-1.
// ---------------------------------------------------------------------------
module tb_dpb_stream_reader;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [AW:0]   i_count;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_bram_addr;
    logic          o_bram_we;
    logic [DW-1:0] o_bram_din;
    logic [DW-1:0] i_bram_dout;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_last;
`ifdef DPB_READER_CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] mem [0:DEPTH-1];

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h100);
    end

    always @(posedge clk) i_bram_dout <= mem[o_bram_addr];

    dpb_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
`ifdef DPB_READER_CHECKSUM_EN
        .o_checksum  (o_checksum),
`endif
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_count     (i_count),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_bram_addr (o_bram_addr),
        .o_bram_we   (o_bram_we),
        .o_bram_din  (o_bram_din),
        .i_bram_dout (i_bram_dout),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_last      (o_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_at(input int a);
        return DW'((a & (DEPTH - 1)) + 'h100);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 64'(o_busy), 64'(0));
        check({tag, "_done"}, 64'(o_done), 64'(0));
        check({tag, "_addr"}, 64'(o_bram_addr), 64'(0));
        check({tag, "_valid"}, 64'(o_valid), 64'(0));
        check({tag, "_data"}, 64'(o_data), 64'(0));
        check({tag, "_last"}, 64'(o_last), 64'(0));
        check({tag, "_we"}, 64'(o_bram_we), 64'(0));
        check({tag, "_din"}, 64'(o_bram_din), 64'(0));
`ifdef DPB_READER_CHECKSUM_EN
        check({tag, "_csum"}, 64'(o_checksum), 64'(0));
`endif
    endtask

    // One transfer. Everything is driven and sampled on the falling edge;
    // sample k sits between rising edges E(k) and E(k+1), E0 being the start edge.
    // inject_k >= 0 pulses a junk i_start at that sample; abort_at > 0 asserts
    // rst once that many beats have been accepted.
    task automatic run_xfer(input int base, input int cnt, input int ready_pct,
                            input int inject_k, input int abort_at,
                            output logic [DW-1:0] csum_seen);
        int            k;
        int            beats;
        int            budget;
        int            ahead;
        bit            done_seen;
        bit            seen_valid;
        bit            aborted;
        logic [DW-1:0] xr;
        logic [DW-1:0] exp_w;

        budget     = cnt * 30 + 50;
        k          = 0;
        beats      = 0;
        done_seen  = 1'b0;
        seen_valid = 1'b0;
        aborted    = 1'b0;
        xr         = '0;
        csum_seen  = '0;

        @(negedge clk);
        i_start     = 1'b1;
        i_base_addr = AW'(base);
        i_count     = (AW + 1)'(cnt);
        @(negedge clk);
        i_start = 1'b0;

        while (k < budget) begin
            i_start = (k == inject_k);
            if (i_start) begin
                i_base_addr = AW'($urandom);
                i_count     = (AW + 1)'($urandom_range(1, 50));
            end

            if (o_done) begin
                done_seen = 1'b1;
                check("done_beats", 64'(beats), 64'(cnt));
                check("done_busy", 64'(o_busy), 64'(0));
                check("done_valid", 64'(o_valid), 64'(0));
                if (cnt == 0) check("done_lat_zero", 64'(k), 64'(0));
                else if (ready_pct >= 100) check("done_lat", 64'(k), 64'(cnt + 2));
`ifdef DPB_READER_CHECKSUM_EN
                csum_seen = o_checksum;
                check("checksum", 64'(o_checksum), 64'(xr));
`endif
                break;
            end

            check("busy", 64'(o_busy), 64'(1));
            if (o_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    check("first_valid", 64'(k), 64'(2));
                end
                check("beat_in_range", 64'(beats < cnt), 64'(1));
                exp_w = word_at(base + beats);
                check("data", 64'(o_data), 64'(exp_w));
                check("last", 64'(o_last), 64'(beats == cnt - 1));
            end
            if (cnt < DEPTH) begin
                ahead = ((int'(o_bram_addr) - base) & (DEPTH - 1)) - beats;
                check("reads_ahead", 64'(ahead <= 2), 64'(1));
            end

            if (abort_at > 0 && beats == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_reset("abort");
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end

            i_ready = ($urandom_range(0, 99) < ready_pct);
            if (o_valid && i_ready) begin
                xr = xr ^ word_at(base + beats);
                beats++;
            end
            @(negedge clk);
            k++;
        end

        i_start = 1'b0;
        if (!aborted) begin
            if (!done_seen) begin
                check("timeout", 64'(0), 64'(1));
            end else begin
                @(negedge clk);
                check("idle_done", 64'(o_done), 64'(0));
                check("idle_busy", 64'(o_busy), 64'(0));
                check("idle_valid", 64'(o_valid), 64'(0));
            end
        end
    endtask

    initial begin
        logic [DW-1:0] cs;

        rst         = 1'b1;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_count     = '0;
        i_ready     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Basic full-rate block
        run_xfer('h010, 4, 100, -1, 0, cs);

        // Backpressure, fixed and random lengths from random bases
        repeat (3) run_xfer(int'($urandom_range(0, DEPTH - 1)), 8, 50, -1, 0, cs);
        repeat (3) run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 60, -1, 0, cs);

        // Wrap across the top address
        run_xfer('h3FE, 4, 100, -1, 0, cs);

        // Edges: empty transfer, full-depth transfer, start while busy
        run_xfer(int'($urandom_range(0, DEPTH - 1)), 0, 100, -1, 0, cs);
        run_xfer('h200, DEPTH, 100, -1, 0, cs);
        run_xfer('h040, 12, 70, 3, 0, cs);
        repeat (3) @(negedge clk);
        check("ignored_start_busy", 64'(o_busy), 64'(0));
        check("ignored_start_valid", 64'(o_valid), 64'(0));

        // Reset mid-transfer, then a clean restart
        run_xfer('h080, 16, 100, -1, 6, cs);
        run_xfer('h155, 5, 100, -1, 0, cs);

`ifdef DPB_READER_CHECKSUM_EN
        run_xfer(0, 4, 100, -1, 0, cs);
        check("csum_base0", 64'(cs), 64'(32'h0000_0000));
        run_xfer(1, 4, 40, -1, 0, cs);
        check("csum_base1", 64'(cs), 64'(32'h0000_0004));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
